// File: rtl/prom_pkg.sv
// Shared widths, state encoding and reset constants for the PROM reader and
// the PROM shadowing loader that will reuse its wait timer.
package prom_pkg;

    localparam int PROM_ADDR_W = 8;
    localparam int PROM_NIB_W  = 4;
    localparam int PROM_DATA_W = 2 * PROM_NIB_W;
    localparam int PROM_CNT_W  = 9;

    localparam logic PROM_CE_N_RST = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        OUT
    } prom_state_t;

endpackage

// File: rtl/prom_wait_timer.sv
// 8-bit down counter with synchronous load and a zero flag; it times the
// PROM access window and stops at zero rather than wrapping.
module prom_wait_timer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [7:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= 8'd0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != 8'd0)) begin
            r_count <= r_count - 8'd1;
        end
    end

    assign o_zero = (r_count == 8'd0);

endmodule

// File: rtl/prom_reader.sv
// Burst read master for two 256x4 bipolar PROMs used as one 256x8 array,
// streaming each assembled byte with its address and a running checksum.
module prom_reader
    import prom_pkg::*;
#(
    parameter int ACCESS_CYCLES = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [PROM_ADDR_W-1:0] i_start_addr,
    input  logic [PROM_CNT_W-1:0]  i_count,
    output logic [PROM_ADDR_W-1:0] o_prom_addr,
    output logic                   o_prom_ce_n,
    input  logic [PROM_NIB_W-1:0]  i_prom_d_hi,
    input  logic [PROM_NIB_W-1:0]  i_prom_d_lo,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [PROM_DATA_W-1:0] o_out_data,
    output logic [PROM_ADDR_W-1:0] o_out_addr,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [PROM_DATA_W-1:0] o_checksum
);

    // Timer reload leaves ACCESS_CYCLES full periods between address setup and capture.
    localparam logic [7:0] WAIT_RELOAD = 8'(ACCESS_CYCLES - 1);

    prom_state_t r_state;
    prom_state_t w_next_state;

    logic [PROM_ADDR_W-1:0] r_prom_addr;
    logic                   r_prom_ce_n;
    logic                   r_out_valid;
    logic [PROM_DATA_W-1:0] r_out_data;
    logic [PROM_ADDR_W-1:0] r_out_addr;
    logic                   r_busy;
    logic                   r_done;
    logic [PROM_DATA_W-1:0] r_checksum;
    logic [PROM_CNT_W-1:0]  r_remaining;

    logic                   w_timer_zero;
    logic                   w_start_burst;
    logic                   w_start_empty;
    logic                   w_capture;
    logic                   w_handshake;
    logic                   w_last;
    logic                   w_reload;
    logic [PROM_DATA_W-1:0] w_byte;

    assign w_byte = {i_prom_d_hi, i_prom_d_lo};

    prom_wait_timer u_wait_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_reload),
        .i_load_val (WAIT_RELOAD),
        .i_dec      (r_state == WAIT),
        .o_zero     (w_timer_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (w_start_burst) w_next_state = WAIT;
            WAIT: if (w_timer_zero)  w_next_state = OUT;
            OUT: begin
                if (w_handshake) w_next_state = w_last ? IDLE : WAIT;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        w_start_burst = 1'b0;
        w_start_empty = 1'b0;
        w_capture     = 1'b0;
        w_handshake   = 1'b0;
        w_last        = 1'b0;
        case (r_state)
            IDLE: begin
                w_start_burst = i_start && (i_count != '0);
                w_start_empty = i_start && (i_count == '0);
            end
            WAIT: w_capture = w_timer_zero;
            OUT: begin
                w_handshake = r_out_valid && i_out_ready;
                w_last      = w_handshake && (r_remaining == 9'd1);
            end
            default: ;
        endcase
        w_reload = w_start_burst || (w_handshake && !w_last);
    end

    // Address and CE only move on burst start and after a handshake, so they
    // stay stable for the whole access window and while a byte is offered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prom_addr <= '0;
            r_prom_ce_n <= PROM_CE_N_RST;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_addr  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_checksum  <= '0;
            r_remaining <= '0;
        end else begin
            r_done <= w_start_empty || w_last;
            if (w_start_empty) begin
                r_checksum <= '0;
            end
            if (w_start_burst) begin
                r_prom_addr <= i_start_addr;
                r_prom_ce_n <= 1'b0;
                r_remaining <= i_count;
                r_checksum  <= '0;
                r_busy      <= 1'b1;
            end
            if (w_capture) begin
                r_out_data  <= w_byte;
                r_out_addr  <= r_prom_addr;
                r_checksum  <= r_checksum + w_byte;
                r_out_valid <= 1'b1;
            end
            if (w_handshake) begin
                r_out_valid <= 1'b0;
                if (w_last) begin
                    r_prom_ce_n <= 1'b1;
                    r_busy      <= 1'b0;
                end else begin
                    r_prom_addr <= r_prom_addr + 8'd1;
                    r_remaining <= r_remaining - 9'd1;
                end
            end
        end
    end

    assign o_prom_addr = r_prom_addr;
    assign o_prom_ce_n = r_prom_ce_n;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;
    assign o_out_addr  = r_out_addr;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_checksum  = r_checksum;

endmodule

// File: tb/tb_prom_reader.sv
// Directed bench for prom_reader: one instance at ACCESS_CYCLES=8 for the
// monitor-image read, one at ACCESS_CYCLES=3 for bursts, stalls and reset.
module tb_prom_reader;

    logic clk = 1'b0;
    logic rstN = 1'b0;
    logic start8 = 1'b0;
    logic start3 = 1'b0;
    logic [7:0] startAddr = 8'h00;
    logic [8:0] count = 9'd0;
    logic outReady = 1'b1;

    logic [7:0] addr8, data8, oaddr8, sum8, byte8;
    logic ceN8, valid8, busy8, done8;
    logic [7:0] addr3, data3, oaddr3, sum3, byte3;
    logic ceN3, valid3, busy3, done3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // PROM image: byte at address a is a*7 + 0xD8, so address 0 holds 0xD8.
    function automatic logic [7:0] romByte(input logic [7:0] a);
        return a * 8'd7 + 8'hD8;
    endfunction

    assign byte8 = romByte(addr8);
    assign byte3 = romByte(addr3);

    prom_reader #(.ACCESS_CYCLES(8)) dut8 (
        .clk(clk), .rst_n(rstN), .i_start(start8), .i_start_addr(startAddr),
        .i_count(count), .o_prom_addr(addr8), .o_prom_ce_n(ceN8),
        .i_prom_d_hi(byte8[7:4]), .i_prom_d_lo(byte8[3:0]),
        .o_out_valid(valid8), .i_out_ready(outReady), .o_out_data(data8),
        .o_out_addr(oaddr8), .o_busy(busy8), .o_done(done8), .o_checksum(sum8)
    );

    prom_reader #(.ACCESS_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rstN), .i_start(start3), .i_start_addr(startAddr),
        .i_count(count), .o_prom_addr(addr3), .o_prom_ce_n(ceN3),
        .i_prom_d_hi(byte3[7:4]), .i_prom_d_lo(byte3[3:0]),
        .o_out_valid(valid3), .i_out_ready(outReady), .o_out_data(data3),
        .o_out_addr(oaddr3), .o_busy(busy3), .o_done(done3), .o_checksum(sum3)
    );

    // PROM-side timing check on dut3: every capture must follow at least three
    // periods of stable address with CE low.
    initial begin
        int holdCnt = 0;
        logic [7:0] prevAddr = 8'h00;
        logic prevCe = 1'b1;
        logic prevValid = 1'b0;
        forever begin
            @(negedge clk);
            if (valid3 && !prevValid) begin
                checks++;
                if (holdCnt < 3) begin
                    errors++;
                    $display("[TB] FAIL prom_hold: held %0d cycles, need >= 3", holdCnt);
                end
            end
            if (!ceN3 && !prevCe && addr3 == prevAddr) holdCnt++;
            else if (!ceN3) holdCnt = 1;
            else holdCnt = 0;
            prevAddr = addr3;
            prevCe = ceN3;
            prevValid = valid3;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        tick(2);
        rstN = 1'b1;
        tick(1);
        checks++; if (ceN3 !== 1'b1) begin errors++; $display("[TB] FAIL reset_ce_n: got %b want 1", ceN3); end
        checks++; if (addr3 !== 8'h00) begin errors++; $display("[TB] FAIL reset_addr: got %h want 00", addr3); end
        checks++; if (valid3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b want 0", valid3); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy3); end
        checks++; if (sum3 !== 8'h00) begin errors++; $display("[TB] FAIL reset_checksum: got %h want 00", sum3); end
        checks++; if (ceN8 !== 1'b1) begin errors++; $display("[TB] FAIL reset_ce_n8: got %b want 1", ceN8); end
    endtask

    task automatic test_monitor_read();
        int seen = -1;
        startAddr = 8'h00; count = 9'd1; outReady = 1'b1; start8 = 1'b1;
        tick(1);
        start8 = 1'b0;
        checks++; if (busy8 !== 1'b1 || ceN8 !== 1'b0) begin errors++; $display("[TB] FAIL mon_start: busy %b ce_n %b want 1 0", busy8, ceN8); end
        for (int c = 1; c <= 20; c++) begin
            tick(1);
            if (valid8) begin seen = c; break; end
        end
        checks++; if (seen != 8) begin errors++; $display("[TB] FAIL mon_latency: got %0d want 8", seen); end
        checks++; if (data8 !== 8'hD8) begin errors++; $display("[TB] FAIL mon_data: got %h want d8", data8); end
        checks++; if (oaddr8 !== 8'h00) begin errors++; $display("[TB] FAIL mon_addr: got %h want 00", oaddr8); end
        checks++; if (done8 !== 1'b0) begin errors++; $display("[TB] FAIL mon_done_early: got %b want 0", done8); end
        tick(1);
        checks++; if (done8 !== 1'b1 || busy8 !== 1'b0) begin errors++; $display("[TB] FAIL mon_done: done %b busy %b want 1 0", done8, busy8); end
        checks++; if (sum8 !== 8'hD8) begin errors++; $display("[TB] FAIL mon_checksum: got %h want d8", sum8); end
        checks++; if (ceN8 !== 1'b1 || valid8 !== 1'b0) begin errors++; $display("[TB] FAIL mon_end: ce_n %b valid %b want 1 0", ceN8, valid8); end
        tick(1);
        checks++; if (done8 !== 1'b0) begin errors++; $display("[TB] FAIL mon_done_pulse: got %b want 0", done8); end
    endtask

    task automatic test_burst_wrap();
        logic [7:0] expAddr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        logic [7:0] expData [4] = '{8'hCA, 8'hD1, 8'hD8, 8'hDF};
        int idx = 0;
        int doneAt = -1;
        startAddr = 8'hFE; count = 9'd4; outReady = 1'b1; start3 = 1'b1;
        tick(1);
        start3 = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick(1);
            if (valid3 && idx < 4) begin
                checks++; if (c != 3 + 4 * idx) begin errors++; $display("[TB] FAIL burst_time%0d: got %0d want %0d", idx, c, 3 + 4 * idx); end
                checks++; if (oaddr3 !== expAddr[idx]) begin errors++; $display("[TB] FAIL burst_addr%0d: got %h want %h", idx, oaddr3, expAddr[idx]); end
                checks++; if (data3 !== expData[idx]) begin errors++; $display("[TB] FAIL burst_data%0d: got %h want %h", idx, data3, expData[idx]); end
                idx++;
            end
            if (done3) begin doneAt = c; break; end
        end
        checks++; if (idx != 4) begin errors++; $display("[TB] FAIL burst_count: got %0d want 4", idx); end
        checks++; if (doneAt != 16) begin errors++; $display("[TB] FAIL burst_done: got %0d want 16", doneAt); end
        checks++; if (sum3 !== 8'h52 || busy3 !== 1'b0) begin errors++; $display("[TB] FAIL burst_sum: sum %h busy %b want 52 0", sum3, busy3); end
        tick(1);
    endtask

    task automatic test_backpressure();
        logic [7:0] expAddr [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
        logic [7:0] expData [4] = '{8'hCA, 8'hD1, 8'hD8, 8'hDF};
        int expCyc [4] = '{3, 7, 16, 20};
        int idx = 0;
        int doneAt = -1;
        int stall = 0;
        logic prevValid = 1'b0;
        startAddr = 8'hFE; count = 9'd4; outReady = 1'b1; start3 = 1'b1;
        tick(1);
        start3 = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            tick(1);
            if (valid3 && !prevValid) begin
                checks++; if (idx > 3 || c != expCyc[idx]) begin errors++; $display("[TB] FAIL bp_time%0d: got %0d", idx, c); end
                checks++; if (idx > 3 || oaddr3 !== expAddr[idx] || data3 !== expData[idx]) begin errors++; $display("[TB] FAIL bp_byte%0d: got %h/%h", idx, oaddr3, data3); end
                if (idx == 1) begin outReady = 1'b0; stall = 5; end
                idx++;
            end else if (valid3 && prevValid) begin
                checks++; if (addr3 !== 8'hFF || oaddr3 !== 8'hFF || data3 !== 8'hD1) begin errors++; $display("[TB] FAIL bp_hold: prom_addr %h out_addr %h data %h want ff ff d1", addr3, oaddr3, data3); end
                if (stall > 0) begin
                    stall--;
                    if (stall == 0) outReady = 1'b1;
                end
            end
            prevValid = valid3;
            if (done3) begin doneAt = c; break; end
        end
        outReady = 1'b1;
        checks++; if (idx != 4) begin errors++; $display("[TB] FAIL bp_count: got %0d want 4", idx); end
        checks++; if (doneAt != 21) begin errors++; $display("[TB] FAIL bp_done: got %0d want 21", doneAt); end
        checks++; if (sum3 !== 8'h52) begin errors++; $display("[TB] FAIL bp_sum: got %h want 52", sum3); end
        tick(1);
    endtask

    task automatic test_count_zero();
        startAddr = 8'h33; count = 9'd0; start3 = 1'b1;
        tick(1);
        start3 = 1'b0;
        checks++; if (done3 !== 1'b1) begin errors++; $display("[TB] FAIL zero_done: got %b want 1", done3); end
        checks++; if (busy3 !== 1'b0 || ceN3 !== 1'b1) begin errors++; $display("[TB] FAIL zero_idle: busy %b ce_n %b want 0 1", busy3, ceN3); end
        checks++; if (sum3 !== 8'h00) begin errors++; $display("[TB] FAIL zero_sum: got %h want 00", sum3); end
        tick(1);
        checks++; if (done3 !== 1'b0 || ceN3 !== 1'b1) begin errors++; $display("[TB] FAIL zero_after: done %b ce_n %b want 0 1", done3, ceN3); end
    endtask

    task automatic test_start_while_busy();
        int idx = 0;
        int doneAt = -1;
        logic [7:0] expAddr [2] = '{8'h10, 8'h11};
        logic [7:0] expData [2] = '{8'h48, 8'h4F};
        startAddr = 8'h10; count = 9'd2; outReady = 1'b1; start3 = 1'b1;
        tick(1);
        startAddr = 8'h80; count = 9'd1;
        for (int c = 1; c <= 30; c++) begin
            tick(1);
            if (valid3 && idx < 2) begin
                checks++; if (oaddr3 !== expAddr[idx] || data3 !== expData[idx]) begin errors++; $display("[TB] FAIL busy_byte%0d: got %h/%h want %h/%h", idx, oaddr3, data3, expAddr[idx], expData[idx]); end
                idx++;
            end
            if (done3) begin doneAt = c; start3 = 1'b0; break; end
        end
        start3 = 1'b0;
        checks++; if (idx != 2 || doneAt != 8) begin errors++; $display("[TB] FAIL busy_done: bytes %0d at %0d want 2 at 8", idx, doneAt); end
        checks++; if (sum3 !== 8'h97) begin errors++; $display("[TB] FAIL busy_sum: got %h want 97", sum3); end
        tick(1);
        checks++; if (busy3 !== 1'b0) begin errors++; $display("[TB] FAIL busy_restart: got %b want 0", busy3); end
    endtask

    task automatic test_reset_mid_burst();
        int seen = -1;
        int doneAt = -1;
        startAddr = 8'h20; count = 9'd3; outReady = 1'b0; start3 = 1'b1;
        tick(1);
        start3 = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            tick(1);
            if (valid3) begin seen = c; break; end
        end
        checks++; if (seen != 3) begin errors++; $display("[TB] FAIL rst_pre_valid: got %0d want 3", seen); end
        tick(2);
        rstN = 1'b0;
        tick(1);
        rstN = 1'b1;
        checks++; if (addr3 !== 8'h00 || ceN3 !== 1'b1 || valid3 !== 1'b0) begin errors++; $display("[TB] FAIL rst_bus: addr %h ce_n %b valid %b want 00 1 0", addr3, ceN3, valid3); end
        checks++; if (data3 !== 8'h00 || oaddr3 !== 8'h00) begin errors++; $display("[TB] FAIL rst_out: data %h addr %h want 00 00", data3, oaddr3); end
        checks++; if (busy3 !== 1'b0 || done3 !== 1'b0 || sum3 !== 8'h00) begin errors++; $display("[TB] FAIL rst_status: busy %b done %b sum %h want 0 0 00", busy3, done3, sum3); end
        outReady = 1'b1; startAddr = 8'h40; count = 9'd1; start3 = 1'b1;
        tick(1);
        start3 = 1'b0;
        seen = -1;
        for (int c = 1; c <= 20; c++) begin
            tick(1);
            if (valid3 && seen < 0) begin
                seen = c;
                checks++; if (oaddr3 !== 8'h40 || data3 !== 8'h98) begin errors++; $display("[TB] FAIL rst_new_byte: got %h/%h want 40/98", oaddr3, data3); end
            end
            if (done3) begin doneAt = c; break; end
        end
        checks++; if (seen != 3 || doneAt != 4) begin errors++; $display("[TB] FAIL rst_new_timing: valid %0d done %0d want 3 4", seen, doneAt); end
        checks++; if (sum3 !== 8'h98) begin errors++; $display("[TB] FAIL rst_new_sum: got %h want 98", sum3); end
    endtask

    initial begin
        test_reset();
        test_monitor_read();
        test_burst_wrap();
        test_backpressure();
        test_count_zero();
        test_start_while_busy();
        test_reset_mid_burst();
        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
